mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the 54-instruction CPU. Executes MULT, MULTU, DIV and DIVU.
- Sits directly upstream of the HI and LO registers and drives their data inputs and enables.
- `busy` is used by control to deassert the PC register enable (stall) while an operation is in flight.
- All state updates on the falling edge of `clk`, matching the PC and HI/LO registers.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on negedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  high from the accepting edge until the edge that returns to IDLE.
- done  out  1  one-cycle pulse; results valid in this cycle.
- hi_out  out  WIDTH  to HI data_in: product high word / remainder.
- lo_out  out  WIDTH  to LO data_in: product low word / quotient.
- hilo_we  out  1  HI and LO enable. Equals `done`.

Behaviour:
- Reset: async, to IDLE. busy=0, done=0, hilo_we=0, hi_out=0, lo_out=0, counter=0, internal registers=0.
- Reset mid-operation aborts the operation; no hilo_we is ever issued for it.
- States: IDLE, RUN, FINISH.
- IDLE -> RUN on a falling edge with start=1.
  - Latch op.
  - Latch |a| and |b|: magnitudes for signed ops, raw values for unsigned.
  - Latch sign flags. counter=0. busy=1.
  - a and b may change after the accepting edge.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per edge. counter increments each step.
- RUN -> FINISH on the edge where counter reaches WIDTH-1, i.e. after WIDTH steps.
- FINISH -> IDLE on the next edge, which also:
  - applies sign correction;
  - loads hi_out/lo_out;
  - pulses done=hilo_we=1 for exactly one cycle;
  - deasserts busy.
- Latency: start sampled at edge N gives done high in the cycle following edge N+WIDTH+1, i.e. 34 edges for WIDTH=32. busy falls on that same edge.
- hi_out/lo_out hold their last result until the next done. Only the hilo_we pulse causes HI/LO writes.
- start while busy=1 is ignored, not queued. start held high across done begins a new op on the edge after returning to IDLE.
- Multiply: 2*WIDTH-bit product of magnitudes. Negated (two's complement, 2*WIDTH bits) for MULT when the operand signs differ. hi_out=product[2W-1:W], lo_out=product[W-1:0].
- Divide: quotient/remainder computed on magnitudes.
  - Quotient negated when the signs differ (DIV only).
  - Remainder takes the dividend's sign (DIV only).
- Divide by zero completes with normal latency:
  - DIVU: lo=all-ones, hi=a.
  - DIV: hi=a; lo = 1 if a<0, else all-ones.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- MULT of 0x80000000 * 0x80000000: hi=0x40000000, lo=0.

Optional Feature:
- Macro: MDU_ZERO_FAST_EN.
- Defined: at the accepting edge, if a==0 or b==0, go directly to FINISH with results preloaded. done follows 2 edges after start.
  - Multiply gives 0:0.
  - Divide with b==0 gives the divide-by-zero values above.
  - Divide with a==0, b!=0 gives 0:0.
- Undefined: all operations take full latency. Result values are identical in both builds.

Decomposition:
- Package mdu_pkg:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - state enum (IDLE, RUN, FINISH);
  - WIDTH default;
  - divide-by-zero quotient constant.
- One combinational sub-module: mdu_div_step. It is one restoring-division step: inputs remainder, quotient and divisor; outputs the next remainder and quotient.
- Multiply step stays inline.

Test Plan:
- Reset held, then released → all outputs 0. DIVU a=100, b=7 → after 34 edges done=1 once, lo=14, hi=2, hilo_we=1.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=-5, b=0 → lo=1, hi=0xFFFFFFFB.
- start pulsed at edge 10 of a running op → ignored, one done only. rst asserted at edge 20 → busy=0 immediately, no hilo_we; new op then completes with normal latency.
- MDU_ZERO_FAST_EN defined, MULT a=0, b=9 → done 2 edges after start, hi=lo=0. Same stimulus with the macro undefined → 34 edges, same values.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and constants for the iterative MDU
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Quotient magnitude produced by a divide by zero; sliced down to the operand width.
  localparam logic [63:0] DIV0_QUO = '1;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           take;

  // Shift the next dividend bit into the partial remainder and subtract when it fits.
  // While rem < divisor the top bit of diff is a clean borrow flag; with a zero
  // divisor it stays clear, so the quotient fills with ones and rem becomes the dividend.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    take     = ~diff[WIDTH];
    rem_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], take};
  end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit feeding HI/LO; MDU_ZERO_FAST_EN enables zero-operand shortcut
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hilo_we
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       op_r;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] q;     // multiplier shifting into product low half / dividend into quotient
  logic [WIDTH-1:0] m;     // multiplicand / divisor magnitude

  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] mul_q_next;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign hilo_we = done;

  // Operand magnitudes and sign flags; unsigned ops take the raw values.
  always_comb begin
    in_sa = op[0] & a[WIDTH-1];
    in_sb = op[0] & b[WIDTH-1];
    mag_a = in_sa ? -a : a;
    mag_b = in_sb ? -b : b;
  end

  // Shift-add multiply step: add multiplicand when the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    {mul_acc_next, mul_q_next} = {mul_sum, q[WIDTH-1:1]};
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc),
    .quo      (q),
    .divisor  (m),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  // Sign correction applied on the way out: product negated for MULT with differing signs,
  // quotient negated for DIV with differing signs, remainder follows the dividend sign.
  always_comb begin
    prod   = {acc, q};
    fin_hi = acc;
    fin_lo = q;
    if (!op_r[1]) begin
      if (op_r == OP_MULT && (sign_a ^ sign_b)) begin
        prod = -prod;
      end
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (op_r == OP_DIV) begin
      if (sign_a ^ sign_b) begin
        fin_lo = -q;
      end
      if (sign_a) begin
        fin_hi = -acc;
      end
    end
  end

  // Control FSM and datapath registers, all on the falling edge to line up with PC and HI/LO.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            sign_a <= in_sa;
            sign_b <= in_sb;
            count  <= '0;
            busy   <= 1'b1;
`ifdef MDU_ZERO_FAST_EN
            if (a == '0 || b == '0) begin
              // Results preloaded so that FINISH's sign correction yields the final values.
              state <= FINISH;
              m     <= '0;
              if (op[1] && b == '0) begin
                acc <= mag_a;
                q   <= DIV0_QUO[WIDTH-1:0];
              end else begin
                acc <= '0;
                q   <= '0;
              end
            end else begin
              state <= RUN;
              acc   <= '0;
              q     <= op[1] ? mag_a : mag_b;
              m     <= op[1] ? mag_b : mag_a;
            end
`else
            state <= RUN;
            acc   <= '0;
            q     <= op[1] ? mag_a : mag_b;
            m     <= op[1] ? mag_b : mag_a;
`endif
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (op_r[1]) begin
            acc <= div_rem_next;
            q   <= div_quo_next;
          end else begin
            acc <= mul_acc_next;
            q   <= mul_q_next;
          end
          if (count == LAST_STEP) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          hi_out <= fin_hi;
          lo_out <= fin_lo;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
